// File: rtl/pcu_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
package pcu_pkg;

    localparam int unsigned PC_W_DEF = 8;
    localparam int unsigned CNT_W    = 16;
    localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = 8'h00;

    typedef logic [PC_W_DEF-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } pcu_state_e;

    // Saturating increment for the redirect counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/program_counter_unit_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry.
module return_address_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_c,
    output logic         full_c,
    output logic         empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [LVL_W-1:0] level;

    // sp points at the next free slot; wrapping it makes overwrite-oldest implicit.
    assign top_c   = mem[sp - PTR_W'(1)];
    assign full_c  = (level == LVL_W'(DEPTH));
    assign empty_c = (level == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            level <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (pop && !empty_c) begin
            sp    <= sp - PTR_W'(1);
            level <= level - LVL_W'(1);
        end else if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + PTR_W'(1);
            if (!full_c) begin
                level <= level + LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-stage PC sequencer with one-bubble redirects and a valid/ready fetch port.
// Optional return-address stack enabled by defining PCU_RAS_EN.
module program_counter_unit
    import pcu_pkg::*;
#(
    parameter int unsigned       PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0]   RESET_PC  = PC_W'(RESET_PC_DEF),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             call,
    input  logic             ret,
    input  logic             fetch_ready,
    output logic [PC_W-1:0]  fetch_addr,
    output logic             fetch_valid,
    output logic [CNT_W-1:0] branch_count,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    pcu_state_e      state;
    logic            idle_wait;
    logic            active_c;
    logic            fire_c;
    logic [PC_W-1:0] pc_inc_c;
    logic            ret_take_c;
    logic            call_take_c;
    logic [PC_W-1:0] ras_top_c;
    logic            ras_full_c;
    logic            ras_empty_c;

    assign active_c = (state != IDLE);
    assign fire_c   = fetch_valid & fetch_ready;
    assign pc_inc_c = fetch_addr + PC_W'(1);

`ifdef PCU_RAS_EN
    logic ras_push_c;
    logic ras_pop_c;

    // ret outranks call; branch_taken outranks both.
    assign ret_take_c  = active_c & ~branch_taken & ret;
    assign call_take_c = active_c & ~branch_taken & ~ret & call;
    assign ras_push_c  = call_take_c;
    assign ras_pop_c   = ret_take_c & ~ras_empty_c;

    return_address_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push_c),
        .pop       (ras_pop_c),
        .push_data (pc_inc_c),
        .top_c     (ras_top_c),
        .full_c    (ras_full_c),
        .empty_c   (ras_empty_c)
    );
`else
    logic unused_cfg_c;

    // Without a stack, call is a plain jump and ret has no effect.
    assign ret_take_c   = 1'b0;
    assign call_take_c  = active_c & ~branch_taken & call;
    assign ras_top_c    = RESET_PC;
    assign ras_full_c   = 1'b0;
    assign ras_empty_c  = 1'b1;
    assign unused_cfg_c = ^{ret, 32'(RAS_DEPTH)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idle_wait     <= 1'b1;
            fetch_addr    <= RESET_PC;
            fetch_valid   <= 1'b0;
            branch_count  <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Hold off fetching until the second edge after reset release.
                    if (idle_wait) begin
                        idle_wait <= 1'b0;
                    end else begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                    if (branch_taken || ret_take_c || call_take_c) begin
                        state        <= REDIRECT;
                        fetch_valid  <= 1'b0;
                        branch_count <= sat_inc(branch_count);
                        if (branch_taken) begin
                            fetch_addr <= branch_target;
                        end else if (ret_take_c) begin
                            fetch_addr <= ras_empty_c ? RESET_PC : ras_top_c;
                            if (ras_empty_c) begin
                                ras_underflow <= 1'b1;
                            end
                        end else begin
                            fetch_addr <= branch_target;
                            if (ras_full_c) begin
                                ras_overflow <= 1'b1;
                            end
                        end
                    end else if (!stall && fire_c) begin
                        fetch_addr <= pc_inc_c;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed self-checking bench for program_counter_unit (both PCU_RAS_EN builds).
module tb_program_counter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        call;
    logic        ret;
    logic        fetch_ready;
    logic [7:0]  fetch_addr;
    logic        fetch_valid;
    logic [15:0] branch_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    program_counter_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .call          (call),
        .ret           (ret),
        .fetch_ready   (fetch_ready),
        .fetch_addr    (fetch_addr),
        .fetch_valid   (fetch_valid),
        .branch_count  (branch_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [7:0] addr, input logic valid);
        check({tag, "_addr"}, 32'(fetch_addr), 32'(addr));
        check({tag, "_valid"}, 32'(fetch_valid), 32'(valid));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        call = 1'b0; ret = 1'b0; fetch_ready = 1'b1;
        repeat (3) step();
        check_pc("reset", 8'h00, 1'b0);
        check("reset_count", 32'(branch_count), 32'h0);
        check("reset_ovf", 32'(ras_overflow), 32'h0);
        check("reset_unf", 32'(ras_underflow), 32'h0);

        rst = 1'b0;
        step();
        check_pc("idle", 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_pc("seq", 8'(i), 1'b1);
        end

        // Redirect bubble from PC=05.
        branch_taken = 1'b1; branch_target = 8'h34;
        step();
        check_pc("redir", 8'h34, 1'b0);
        check("redir_count", 32'(branch_count), 32'd1);
        branch_taken = 1'b0;
        step();
        check_pc("redir_run", 8'h34, 1'b1);
        step();
        check_pc("redir_adv", 8'h35, 1'b1);

        // Stall and backpressure hold PC.
        stall = 1'b1;
        repeat (3) begin
            step();
            check_pc("stall", 8'h35, 1'b1);
        end
        stall = 1'b0; fetch_ready = 1'b0;
        repeat (2) begin
            step();
            check_pc("bp", 8'h35, 1'b1);
        end
        fetch_ready = 1'b1;
        step();
        check_pc("bp_rel", 8'h36, 1'b1);

        // Redirect honoured during stall, then wrap FE -> FF -> 00.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'hFE;
        step();
        check_pc("stall_redir", 8'hFE, 1'b0);
        check("stall_redir_count", 32'(branch_count), 32'd2);
        stall = 1'b0; branch_taken = 1'b0;
        step();
        check_pc("wrap0", 8'hFE, 1'b1);
        step();
        check_pc("wrap1", 8'hFF, 1'b1);
        step();
        check_pc("wrap2", 8'h00, 1'b1);

`ifdef PCU_RAS_EN
        branch_taken = 1'b1; branch_target = 8'h10;
        step();
        branch_taken = 1'b0;
        step();
        check_pc("to10", 8'h10, 1'b1);
        call = 1'b1; branch_target = 8'h40;
        step();
        check_pc("call", 8'h40, 1'b0);
        check("call_count", 32'(branch_count), 32'd4);
        call = 1'b0;
        step();
        check_pc("call_run", 8'h40, 1'b1);
        ret = 1'b1;
        step();
        check_pc("ret", 8'h11, 1'b0);
        check("ret_count", 32'(branch_count), 32'd5);
        check("ret_unf", 32'(ras_underflow), 32'h0);
        step();
        check_pc("ret_empty", 8'h00, 1'b0);
        check("ret_empty_unf", 32'(ras_underflow), 32'h1);
        ret = 1'b0;
        call = 1'b1; branch_target = 8'h50;
        repeat (4) step();
        check("ovf_4calls", 32'(ras_overflow), 32'h0);
        step();
        check("ovf_5calls", 32'(ras_overflow), 32'h1);
        check_pc("ovf_pc", 8'h50, 1'b0);
        check("ovf_count", 32'(branch_count), 32'd11);
        ret = 1'b1;
        step();
        check_pc("callret", 8'h51, 1'b0);
        check("callret_count", 32'(branch_count), 32'd12);
        call = 1'b0; ret = 1'b0;
        step();
`else
        call = 1'b1; branch_target = 8'h40;
        step();
        check_pc("call", 8'h40, 1'b0);
        check("call_count", 32'(branch_count), 32'd3);
        call = 1'b0;
        step();
        check_pc("call_run", 8'h40, 1'b1);
        ret = 1'b1;
        step();
        check_pc("ret_ignored", 8'h41, 1'b1);
        check("ret_count", 32'(branch_count), 32'd3);
        check("noras_ovf", 32'(ras_overflow), 32'h0);
        check("noras_unf", 32'(ras_underflow), 32'h0);
        ret = 1'b0;
`endif

        // Saturation of branch_count.
        branch_taken = 1'b1; branch_target = 8'h20;
        repeat (65535) @(posedge clk);
        #1;
        check("sat_count", 32'(branch_count), 32'hFFFF);
        check_pc("sat_pc", 8'h20, 1'b0);
        step();
        check("sat_hold", 32'(branch_count), 32'hFFFF);
        branch_taken = 1'b0;
        step();
        check_pc("pre_rst", 8'h20, 1'b1);

        // Asynchronous reset mid-operation.
        #2 rst = 1'b1;
        #1;
        check_pc("async_rst", 8'h00, 1'b0);
        check("async_rst_count", 32'(branch_count), 32'h0);
        check("async_rst_ovf", 32'(ras_overflow), 32'h0);
        check("async_rst_unf", 32'(ras_underflow), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter_unit.md
# program_counter_unit

Registered program-counter sequencer for the 8-bit core's fetch stage. It consumes the branch target (BT) produced by the branch target calculator and redirects fetch to it. It also presents the current fetch address to instruction memory through a valid/ready handshake and inserts one bubble per redirect. It sits between the branch target calculator in decode/execute and the instruction memory port.

## Interface
Parameters:
- PC_W, 8, program-counter width (matches BT width)
- RESET_PC, 8'h00, fetch address after reset
- RAS_DEPTH, 4, return-address-stack entries (power of two; used only with `PCU_RAS_EN`)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  pipeline hazard; hold PC
- branch_taken  in  1  redirect request this cycle
- branch_target  in  PC_W  target from the branch target calculator
- call  in  1  call request: push link, jump to branch_target
- ret  in  1  return request: pop stack into PC
- fetch_ready  in  1  instruction memory accepts fetch_addr
- fetch_addr  out  PC_W  current PC, registered
- fetch_valid  out  1  fetch_addr is a valid request, registered
- branch_count  out  16  number of redirects taken, saturating
- ras_overflow  out  1  sticky flag: push onto a full stack
- ras_underflow  out  1  sticky flag: pop from an empty stack

## Operation
- Reset values: fetch_addr=RESET_PC, fetch_valid=0, branch_count=0, ras_overflow=0, ras_underflow=0, stack empty, state=IDLE.
- States:
  - IDLE: one cycle after reset deasserts, then RUN.
  - RUN: fetch_valid=1.
  - REDIRECT: exactly one cycle with fetch_valid=0, then RUN.
- Fire: fire = fetch_valid & fetch_ready.
- Priority, evaluated each cycle in RUN or REDIRECT, highest first:
  - branch_taken: PC<=branch_target, state<=REDIRECT, branch_count+1.
  - ret: PC<=popped value, state<=REDIRECT, branch_count+1.
  - call: push PC+1, PC<=branch_target, state<=REDIRECT, branch_count+1.
  - stall: PC holds.
  - fire: PC<=PC+1.
  - Otherwise: PC holds.
- Redirect and call/ret requests are honoured even when stall=1 or fetch_ready=0. In IDLE all requests are ignored.
- Arithmetic: PC+1 is modulo 2^PC_W (8'hFF -> 8'h00). branch_count saturates at 16'hFFFF.
- Stack overflow: push when full overwrites the oldest entry (circular) and sets ras_overflow.
- Stack underflow: pop when empty sets ras_underflow and loads RESET_PC.
- Flags: ras_overflow and ras_underflow clear only on rst.
- Simultaneous call and ret: ret wins. The stack is not pushed.
- Reset mid-operation: all state returns to reset values asynchronously. In-flight redirects are discarded.

## Timing
- Redirect at edge N: fetch_addr=target and fetch_valid=0 during cycle N+1; fetch_valid=1 from cycle N+2.
- Sequential advance: fetch_addr changes the cycle after a fire with stall=0.
- Reset release: fetch_valid rises on the second rising edge after rst falls.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `PCU_RAS_EN` defined:
  - RAS_DEPTH-entry return-address stack.
  - call and ret behave as in Operation.
- `PCU_RAS_EN` undefined:
  - No stack storage.
  - call behaves as branch_taken (jump, no push).
  - ret is ignored.
  - ras_overflow and ras_underflow are tied 0.

## Structure
- Shared package pcu_pkg:
  - state enum (IDLE, RUN, REDIRECT)
  - PC_W and RESET_PC defaults
  - pc_t typedef
- One sub-module, return_address_stack: push/pop/full/empty, circular overwrite. Instantiated only under `PCU_RAS_EN`.

## Test plan
- Reset: hold rst, fetch_ready=1, then release rst -> fetch_addr=00 with fetch_valid=0 for one cycle; then fetch_addr sequence 00,01,02 with valid=1.
- Wrap: run from 8'hFE with fetch_ready=1 -> fetch_addr FE, FF, 00.
- Redirect bubble: branch_taken=1 with branch_target=8'h34 while PC=05 -> next cycle fetch_addr=34 with valid=0; then 34 with valid=1; branch_count=1.
- Stall and backpressure: stall=1 for 3 cycles, or fetch_ready=0 -> PC holds. branch_taken during stall still redirects.
- Stack, `PCU_RAS_EN` defined:
  - call to 8'h40 at PC=10, then ret -> PC=11.
  - 5 calls with depth 4 -> ras_overflow=1.
  - ret on an empty stack -> PC=00 and ras_underflow=1.
- Stack, `PCU_RAS_EN` undefined: call to 8'h40 -> PC=40; ret ignored; flags stay 0.
